// File: rtl/hci_outstanding_limiter_if.sv
// Request/response bundle for the HCI-Outstanding path, with one modport for
// each side of the link.
interface hci_outstanding_intf #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned UW = 2,
    parameter int unsigned IW = 4
);
    logic            req_valid;
    logic            req_ready;
    logic [AW-1:0]   add;
    logic            wen;
    logic [DW-1:0]   data;
    logic [DW/8-1:0] be;
    logic [UW-1:0]   user;
    logic [IW-1:0]   id;
    logic            resp_valid;
    logic            resp_ready;
    logic [DW-1:0]   r_data;
    logic [UW-1:0]   r_user;
    logic [IW-1:0]   r_id;
    logic            r_opc;

    modport initiator (
        output req_valid, add, wen, data, be, user, id, resp_ready,
        input  req_ready, resp_valid, r_data, r_user, r_id, r_opc
    );

    modport target (
        input  req_valid, add, wen, data, be, user, id, resp_ready,
        output req_ready, resp_valid, r_data, r_user, r_id, r_opc
    );
endinterface

// File: rtl/hci_outstanding_limiter.sv
// Limits in-flight HCI transactions to MAX_OUTSTANDING, with an optional
// request register slice. Responses pass straight through.
module hci_outstanding_limiter #(
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1),
    parameter bit          REQ_PIPE        = 1'b0,
    parameter int unsigned AW              = 32,
    parameter int unsigned DW              = 32,
    parameter int unsigned UW              = 2,
    parameter int unsigned IW              = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    hci_outstanding_intf.target    tcdm_target,
    hci_outstanding_intf.initiator tcdm_initiator,
    output logic [CNT_W-1:0]      outstanding_o,
    output logic                  idle_o,
    output logic                  err_o
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] cnt;
    logic             err_q;
    logic             cap_ok;
    logic             acc;
    logic             rsp;
    logic             slice_valid;

    // Gating uses only the registered count, so a response never reaches req_ready combinationally.
    assign cap_ok = (cnt < MAX_CNT);
    assign acc    = tcdm_target.req_valid & tcdm_target.req_ready;
    assign rsp    = tcdm_target.resp_valid & tcdm_target.resp_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else if (clear_i) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else if (acc && !rsp) begin
            cnt <= cnt + CNT_W'(1);
        end else if (rsp && !acc) begin
            if (cnt == '0) begin
                err_q <= 1'b1;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    if (REQ_PIPE) begin : g_slice
        logic            sv_q;
        logic [AW-1:0]   add_q;
        logic            wen_q;
        logic [DW-1:0]   data_q;
        logic [DW/8-1:0] be_q;
        logic [UW-1:0]   user_q;
        logic [IW-1:0]   id_q;

        // Fields load only on acceptance, which cannot happen while the slice is stalled.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sv_q   <= 1'b0;
                add_q  <= '0;
                wen_q  <= 1'b0;
                data_q <= '0;
                be_q   <= '0;
                user_q <= '0;
                id_q   <= '0;
            end else if (clear_i) begin
                sv_q <= 1'b0;
            end else if (acc) begin
                sv_q   <= 1'b1;
                add_q  <= tcdm_target.add;
                wen_q  <= tcdm_target.wen;
                data_q <= tcdm_target.data;
                be_q   <= tcdm_target.be;
                user_q <= tcdm_target.user;
                id_q   <= tcdm_target.id;
            end else if (tcdm_initiator.req_ready) begin
                sv_q <= 1'b0;
            end
        end

        assign tcdm_target.req_ready    = cap_ok & (~sv_q | tcdm_initiator.req_ready);
        assign tcdm_initiator.req_valid = sv_q;
        assign tcdm_initiator.add       = add_q;
        assign tcdm_initiator.wen       = wen_q;
        assign tcdm_initiator.data      = data_q;
        assign tcdm_initiator.be        = be_q;
        assign tcdm_initiator.user      = user_q;
        assign tcdm_initiator.id        = id_q;
        assign slice_valid              = sv_q;
    end else begin : g_comb
        assign tcdm_target.req_ready    = tcdm_initiator.req_ready & cap_ok;
        assign tcdm_initiator.req_valid = tcdm_target.req_valid & cap_ok;
        assign tcdm_initiator.add       = tcdm_target.add;
        assign tcdm_initiator.wen       = tcdm_target.wen;
        assign tcdm_initiator.data      = tcdm_target.data;
        assign tcdm_initiator.be        = tcdm_target.be;
        assign tcdm_initiator.user      = tcdm_target.user;
        assign tcdm_initiator.id        = tcdm_target.id;
        assign slice_valid              = 1'b0;
    end

    assign tcdm_target.resp_valid    = tcdm_initiator.resp_valid;
    assign tcdm_target.r_data        = tcdm_initiator.r_data;
    assign tcdm_target.r_user        = tcdm_initiator.r_user;
    assign tcdm_target.r_id          = tcdm_initiator.r_id;
    assign tcdm_target.r_opc         = tcdm_initiator.r_opc;
    assign tcdm_initiator.resp_ready = tcdm_target.resp_ready;

    assign outstanding_o = cnt;
    assign idle_o        = (cnt == '0) & ~slice_valid;
    assign err_o         = err_q;
endmodule

// File: tb/tb_hci_outstanding_limiter.sv
// Directed bench: dut0 is the combinational variant, dut1 the sliced variant,
// both capped at four outstanding requests.
module tb_hci_outstanding_limiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic [2:0] out0, out1;
    logic       idle0, idle1, err0, err1;

    int errors = 0;
    int checks = 0;

    hci_outstanding_intf t0 ();
    hci_outstanding_intf i0 ();
    hci_outstanding_intf t1 ();
    hci_outstanding_intf i1 ();

    hci_outstanding_limiter #(.MAX_OUTSTANDING(4), .REQ_PIPE(1'b0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .tcdm_target(t0), .tcdm_initiator(i0),
        .outstanding_o(out0), .idle_o(idle0), .err_o(err0)
    );

    hci_outstanding_limiter #(.MAX_OUTSTANDING(4), .REQ_PIPE(1'b1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .tcdm_target(t1), .tcdm_initiator(i1),
        .outstanding_o(out1), .idle_o(idle1), .err_o(err1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic reqValid, input logic [31:0] addr, input logic rspValid);
        t0.req_valid  = reqValid;
        t0.add        = addr;
        t0.data       = ~addr;
        i0.resp_valid = rspValid;
        t0.resp_ready = rspValid;
    endtask

    // Stall-stability and count-bound watch on the sliced instance.
    logic        prevStall = 1'b0;
    logic [31:0] prevAdd, prevData;
    always @(negedge clk) begin
        if (!rst_n) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("stableAdd", i1.add, prevAdd);
                checkOutput("stableData", i1.data, prevData);
            end
            checkOutput("cntBound0", 32'(out0 <= 3'd4), 32'd1);
            checkOutput("cntBound1", 32'(out1 <= 3'd4), 32'd1);
            prevStall = i1.req_valid & ~i1.req_ready;
            prevAdd   = i1.add;
            prevData  = i1.data;
        end
    end

    logic [31:0] sbq[$];
    int sent, got, pend, cyc, acc0, firstValid;
    logic readyTog, rspNow;

    initial begin
        t0.req_valid = 0; t0.add = '0; t0.wen = 0; t0.data = '0; t0.be = '1; t0.user = '0; t0.id = '0;
        t0.resp_ready = 0;
        i0.req_ready = 1; i0.resp_valid = 0; i0.r_data = '0; i0.r_user = '0; i0.r_id = '0; i0.r_opc = 0;
        t1.req_valid = 0; t1.add = '0; t1.wen = 0; t1.data = '0; t1.be = '1; t1.user = '0; t1.id = '0;
        t1.resp_ready = 0;
        i1.req_ready = 0; i1.resp_valid = 0; i1.r_data = '0; i1.r_user = '0; i1.r_id = '0; i1.r_opc = 0;

        #3;
        checkOutput("rstOut0", 32'(out0), 0);
        checkOutput("rstIdle0", 32'(idle0), 1);
        checkOutput("rstErr0", 32'(err0), 0);
        checkOutput("rstValid1", 32'(i1.req_valid), 0);
        checkOutput("rstIdle1", 32'(idle1), 1);
        #9 rst_n = 1'b1;
        nextCycle();

        // Six back-to-back requests against a cap of four.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 32'h100 + k, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("capReady%0d", k), 32'(t0.req_ready), (k < 4) ? 1 : 0);
            checkOutput($sformatf("capValid%0d", k), 32'(i0.req_valid), (k < 4) ? 1 : 0);
            if (k == 0) checkOutput("passAdd", i0.add, 32'h100);
            nextCycle();
        end
        applyStimulus(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("fullCount", 32'(out0), 4);

        // Response at the cap frees a slot one cycle later.
        nextCycle();
        applyStimulus(1'b1, 32'h200, 1'b1);
        i0.r_data = 32'hBEEF;
        @(negedge clk);
        checkOutput("readyLowAtRsp", 32'(t0.req_ready), 0);
        checkOutput("rspValidPass", 32'(t0.resp_valid), 1);
        checkOutput("rspDataPass", t0.r_data, 32'hBEEF);
        checkOutput("rspReadyPass", 32'(i0.resp_ready), 1);
        nextCycle();
        applyStimulus(1'b1, 32'h201, 1'b0);
        @(negedge clk);
        checkOutput("countAfterRsp", 32'(out0), 3);
        checkOutput("readyHighNext", 32'(t0.req_ready), 1);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("refill", 32'(out0), 4);

        // Drain to two, then ten cycles of simultaneous accept and response.
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1);
        nextCycle();
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("drainTo2", 32'(out0), 2);
        nextCycle();
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 32'h300 + k, 1'b1);
            nextCycle();
        end
        applyStimulus(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("steady2", 32'(out0), 2);
        checkOutput("steadyErr", 32'(err0), 0);

        // Drain to zero, coincident accept/response at zero, then underflow.
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1);
        nextCycle();
        nextCycle();
        applyStimulus(1'b1, 32'h400, 1'b1);
        @(negedge clk);
        checkOutput("zeroCount", 32'(out0), 0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("coincideCnt", 32'(out0), 0);
        checkOutput("coincideErr", 32'(err0), 0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("underflowErr", 32'(err0), 1);
        checkOutput("underflowCnt", 32'(out0), 0);
        nextCycle();
        @(negedge clk);
        checkOutput("errSticky", 32'(err0), 1);
        nextCycle();
        clear = 1'b1;
        nextCycle();
        clear = 1'b0;
        @(negedge clk);
        checkOutput("clearErr", 32'(err0), 0);
        checkOutput("clearIdle", 32'(idle0), 1);

        // Sliced instance: eight streamed requests, downstream ready toggling.
        nextCycle();
        sent = 0; got = 0; pend = 0; cyc = 0; acc0 = -1; firstValid = -1;
        readyTog = 1'b1;
        t1.resp_ready = 1'b1;
        while ((got < 8 || pend > 0) && cyc < 80) begin
            t1.req_valid  = (sent < 8);
            t1.add        = 32'h800 + 32'(sent) * 4;
            t1.data       = 32'hA000_0000 + 32'(sent) * 32'h11;
            i1.req_ready  = readyTog;
            i1.resp_valid = (pend > 0);
            @(negedge clk);
            rspNow = i1.resp_valid & t1.resp_ready;
            if (i1.req_valid && firstValid < 0) firstValid = cyc;
            if (i1.req_valid && i1.req_ready) begin
                if (sbq.size() == 0) begin
                    checkOutput("spurious", 32'(got), 32'(sent));
                end else begin
                    checkOutput($sformatf("order%0d", got), i1.data, sbq.pop_front());
                end
                got++;
                pend++;
            end
            if (rspNow) pend--;
            if (t1.req_valid && t1.req_ready) begin
                sbq.push_back(t1.data);
                if (sent == 0) acc0 = cyc;
                sent++;
            end
            readyTog = ~readyTog;
            cyc++;
            nextCycle();
        end
        t1.req_valid = 1'b0; i1.resp_valid = 1'b0;
        @(negedge clk);
        checkOutput("streamSent", 32'(sent), 8);
        checkOutput("streamGot", 32'(got), 8);
        checkOutput("latency", 32'(firstValid - acc0), 1);
        checkOutput("streamCnt", 32'(out1), 0);
        checkOutput("streamIdle", 32'(idle1), 1);
        checkOutput("streamErr", 32'(err1), 0);

        // Build cnt=3 with a full stalled slice, then reset mid-cycle.
        nextCycle();
        t1.req_valid = 1'b1;
        i1.req_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            t1.add = 32'hC00 + k;
            nextCycle();
        end
        i1.req_ready = 1'b0;
        @(negedge clk);
        checkOutput("preRstCnt", 32'(out1), 3);
        checkOutput("preRstValid", 32'(i1.req_valid), 1);
        checkOutput("preRstIdle", 32'(idle1), 0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rstCnt", 32'(out1), 0);
        checkOutput("rstValid", 32'(i1.req_valid), 0);
        checkOutput("rstIdle", 32'(idle1), 1);
        t1.req_valid = 1'b0;
        #10 rst_n = 1'b1;
        nextCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
